multicycle_main_fsm: RTL

- Main control state machine of the multicycle ARM datapath.
- Sits beside the instruction decoder. Consumes Op/Funct from the instruction register and sequences fetch, decode, execute, memory and writeback.
- Produces the per-cycle datapath selects and the unconditional write strobes (RegW, MemW, NextPC, Branch). Downstream conditional logic qualifies these strobes with the condition field.
- Inserts wait states while memory is not ready.

---
 rtl/multicycle_main_fsm_if.sv | 31 +++
 rtl/multicycle_main_fsm.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/multicycle_main_fsm_if.sv
// Control bundle between the multicycle main FSM (master) and the datapath/decoder side (slave).
// Carries the instruction fields and memory handshake in, and the per-cycle selects and strobes out.
interface multicycle_main_fsm_if;
   logic [1:0] Op;
   logic [5:0] Funct;
   logic       MemReady;
   logic       IRWrite;
   logic       NextPC;
   logic       AdrSrc;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] ResultSrc;
   logic       ALUOp;
   logic       RegW;
   logic       MemW;
   logic       Branch;
   logic       IllegalOp;
   logic [3:0] State;

   modport master (
      input  Op, Funct, MemReady,
      output IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
             ALUOp, RegW, MemW, Branch, IllegalOp, State
   );

   modport slave (
      output Op, Funct, MemReady,
      input  IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
             ALUOp, RegW, MemW, Branch, IllegalOp, State
   );
endinterface

// File: rtl/multicycle_main_fsm.sv
// Main control FSM of the multicycle ARM datapath (fetch/decode/execute/memory/writeback with wait states).
// Define MCFSM_INSTR_CNT_EN to add the retired-instruction counter output InstrCnt.
module multicycle_main_fsm
`ifdef MCFSM_INSTR_CNT_EN
#(
   parameter int CNT_W = 32
)
`endif
(
   input  logic                  CLK,
   input  logic                  RESET_N,
   multicycle_main_fsm_if.master bus
`ifdef MCFSM_INSTR_CNT_EN
   ,
   output logic [CNT_W-1:0]      InstrCnt
`endif
);

   typedef enum logic [3:0] {
      IDLE     = 4'd0,
      FETCH    = 4'd1,
      DECODE   = 4'd2,
      MEMADR   = 4'd3,
      MEMREAD  = 4'd4,
      MEMWB    = 4'd5,
      MEMWRITE = 4'd6,
      EXECUTER = 4'd7,
      EXECUTEI = 4'd8,
      ALUWB    = 4'd9,
      BRANCH   = 4'd10
   } state_t;

   state_t     r_state;
   state_t     w_next;
   logic       w_irWrite;
   logic       w_nextPc;
   logic       w_adrSrc;
   logic       w_aluSrcA;
   logic [1:0] w_aluSrcB;
   logic [1:0] w_resultSrc;
   logic       w_aluOp;
   logic       w_regW;
   logic       w_memW;
   logic       w_branch;
   logic       w_illegalOp;
   logic       w_unused;

   assign w_unused = &{1'b0, bus.Funct[4:1]};

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) r_state <= IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next      = r_state;
      w_irWrite   = 1'b0;
      w_nextPc    = 1'b0;
      w_adrSrc    = 1'b0;
      w_aluSrcA   = 1'b0;
      w_aluSrcB   = 2'b00;
      w_resultSrc = 2'b00;
      w_aluOp     = 1'b0;
      w_regW      = 1'b0;
      w_memW      = 1'b0;
      w_branch    = 1'b0;
      w_illegalOp = 1'b0;
      case (r_state)
         IDLE: w_next = FETCH;
         FETCH: begin
            w_aluSrcA   = 1'b1;
            w_aluSrcB   = 2'b10;
            w_resultSrc = 2'b10;
            // PC and IR only load on the cycle the memory word is actually delivered.
            w_irWrite   = bus.MemReady;
            w_nextPc    = bus.MemReady;
            w_next      = bus.MemReady ? DECODE : FETCH;
         end
         DECODE: begin
            w_aluSrcA   = 1'b1;
            w_aluSrcB   = 2'b10;
            w_resultSrc = 2'b10;
            case (bus.Op)
               2'b00:   w_next = bus.Funct[5] ? EXECUTEI : EXECUTER;
               2'b01:   w_next = MEMADR;
               2'b10:   w_next = BRANCH;
               default: begin
                  w_next      = FETCH;
                  w_illegalOp = 1'b1;
               end
            endcase
         end
         MEMADR: begin
            w_aluSrcB = 2'b01;
            w_next    = bus.Funct[0] ? MEMREAD : MEMWRITE;
         end
         MEMREAD: begin
            w_adrSrc = 1'b1;
            w_next   = bus.MemReady ? MEMWB : MEMREAD;
         end
         MEMWB: begin
            w_resultSrc = 2'b01;
            w_regW      = 1'b1;
            w_next      = FETCH;
         end
         MEMWRITE: begin
            w_adrSrc = 1'b1;
            w_memW   = 1'b1;
            w_next   = bus.MemReady ? FETCH : MEMWRITE;
         end
         EXECUTER: begin
            w_aluOp = 1'b1;
            w_next  = ALUWB;
         end
         EXECUTEI: begin
            w_aluSrcB = 2'b01;
            w_aluOp   = 1'b1;
            w_next    = ALUWB;
         end
         ALUWB: begin
            w_regW = 1'b1;
            w_next = FETCH;
         end
         BRANCH: begin
            w_aluSrcB   = 2'b10;
            w_resultSrc = 2'b10;
            w_branch    = 1'b1;
            w_next      = FETCH;
         end
         default: w_next = FETCH;
      endcase
   end

   assign bus.IRWrite   = w_irWrite;
   assign bus.NextPC    = w_nextPc;
   assign bus.AdrSrc    = w_adrSrc;
   assign bus.ALUSrcA   = w_aluSrcA;
   assign bus.ALUSrcB   = w_aluSrcB;
   assign bus.ResultSrc = w_resultSrc;
   assign bus.ALUOp     = w_aluOp;
   assign bus.RegW      = w_regW;
   assign bus.MemW      = w_memW;
   assign bus.Branch    = w_branch;
   assign bus.IllegalOp = w_illegalOp;
   assign bus.State     = r_state;

`ifdef MCFSM_INSTR_CNT_EN
   logic             w_retire;
   logic [CNT_W-1:0] r_instrCnt;

   // An instruction retires on the edge that leaves its final state; illegal ops never reach one.
   assign w_retire = (r_state == MEMWB) || (r_state == ALUWB) || (r_state == BRANCH) ||
                     ((r_state == MEMWRITE) && bus.MemReady);

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N)      r_instrCnt <= '0;
      else if (w_retire) r_instrCnt <= r_instrCnt + {{(CNT_W-1){1'b0}}, 1'b1};
   end

   assign InstrCnt = r_instrCnt;
`endif

endmodule
